// File: rtl/viterbi_ber_sequencer.sv
// rtl/viterbi_ber_sequencer.sv - PRBS7 frame sequencer with channel error injection and decoded-bit error counting
// for the convolutional encoder -> channel -> Viterbi decoder BER loop.
module viterbi_ber_sequencer #(
  parameter int FRAME_LEN = 256,
  parameter int TAIL      = 2,
  parameter int DEC_LAT   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic [1:0]  err_mode_i,
  input  logic [7:0]  err_period_i,
  input  logic        enc_valid_i,
  input  logic        dec_bit_i,
  output logic        enc_en_o,
  output logic        enc_bit_o,
  output logic [1:0]  err_mask_o,
  output logic        dec_en_o,
  output logic        busy_o,
  output logic        done_o,
  output logic [15:0] inj_cnt_o,
  output logic [15:0] bit_err_cnt_o
);
  typedef enum logic [2:0] {S_IDLE, S_RUN, S_TAIL, S_DRAIN, S_DONE} state_t;
  localparam int CW = 17;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [6:0]         lfsr_q, lfsr_d;
  logic [1:0]         mode_q, mode_d;
  logic [7:0]         period_q, period_d;
  logic [7:0]         wc_q, wc_d;
  logic               burst_q, burst_d;
  logic               dec_en_q;
  logic [15:0]        inj_q, inj_d;
  logic [15:0]        berr_q, berr_d;
  logic [DEC_LAT-1:0] ref_v_q, ref_v_d, ref_b_q, ref_b_d;
  logic [DEC_LAT:0]   ref_v_sh, ref_b_sh;
  logic               active, launch, word, hit;
  logic [1:0]         mask;

  always_comb begin
    active = (state_q != S_IDLE);
    launch = (state_q == S_IDLE) && start_i && !abort_i;
    word   = active && enc_valid_i;
    hit    = word && (period_q != 8'd0) && (wc_q == period_q - 8'd1);
    mask   = 2'b00;
    if (hit) begin
      case (mode_q)
        2'd1:    mask = 2'b10;
        2'd2:    mask = 2'b11;
        2'd3:    mask = 2'b10;
        default: mask = 2'b00;
      endcase
    end else if (word && burst_q) begin
      mask = 2'b10;
    end
  end

  assign enc_en_o      = (state_q == S_RUN) || (state_q == S_TAIL);
  assign enc_bit_o     = (state_q == S_RUN) && lfsr_q[6];
  assign err_mask_o    = mask;
  assign dec_en_o      = dec_en_q;
  assign busy_o        = active;
  assign done_o        = (state_q == S_DONE);
  assign inj_cnt_o     = inj_q;
  assign bit_err_cnt_o = berr_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 1'b1;
    lfsr_d   = lfsr_q;
    mode_d   = mode_q;
    period_d = period_q;
    wc_d     = wc_q;
    burst_d  = burst_q;
    inj_d    = inj_q;
    berr_d   = berr_q;
    // Reference bits enter the pipe only for data bits; tail and drain slots carry valid=0.
    ref_v_sh = {ref_v_q, (state_q == S_RUN)};
    ref_b_sh = {ref_b_q, enc_bit_o};
    ref_v_d  = ref_v_sh[DEC_LAT-1:0];
    ref_b_d  = ref_b_sh[DEC_LAT-1:0];

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (launch) begin
          state_d  = S_RUN;
          lfsr_d   = 7'h7F;
          mode_d   = err_mode_i;
          period_d = err_period_i;
          wc_d     = 8'd0;
          burst_d  = 1'b0;
          inj_d    = 16'd0;
          berr_d   = 16'd0;
          ref_v_d  = '0;
          ref_b_d  = '0;
        end
      end
      S_RUN: begin
        lfsr_d = {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};
        if (cnt_q == CW'(FRAME_LEN - 1)) begin
          cnt_d   = '0;
          state_d = (TAIL > 0) ? S_TAIL : S_DRAIN;
        end
      end
      S_TAIL: begin
        if (cnt_q == CW'(TAIL - 1)) begin
          cnt_d   = '0;
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (cnt_q == CW'(DEC_LAT + 1)) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (word) begin
      wc_d    = hit ? 8'd0 : wc_q + 8'd1;
      burst_d = hit && (mode_q == 2'd3);
    end
    if ((mask != 2'b00) && (inj_q != 16'hFFFF)) inj_d = inj_q + 16'd1;
    if (active && ref_v_q[DEC_LAT-1] && (ref_b_q[DEC_LAT-1] != dec_bit_i) && (berr_q != 16'hFFFF))
      berr_d = berr_q + 16'd1;

    if (abort_i) state_d = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      lfsr_q   <= 7'h7F;
      mode_q   <= 2'd0;
      period_q <= 8'd0;
      wc_q     <= 8'd0;
      burst_q  <= 1'b0;
      dec_en_q <= 1'b0;
      inj_q    <= 16'd0;
      berr_q   <= 16'd0;
      ref_v_q  <= '0;
      ref_b_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      lfsr_q   <= lfsr_d;
      mode_q   <= mode_d;
      period_q <= period_d;
      wc_q     <= wc_d;
      burst_q  <= burst_d;
      dec_en_q <= enc_valid_i;
      inj_q    <= inj_d;
      berr_q   <= berr_d;
      ref_v_q  <= ref_v_d;
      ref_b_q  <= ref_b_d;
    end
  end
endmodule
